// File: rtl/camera_pkg.sv
// Shared types for the camera capture path.
//   buf_state_t : lifecycle of one frame buffer (FREE -> FILLING -> READY -> HELD)
//   cap_state_t : capture sequencer states
//   LANE_W      : width of one pixel lane inside a write word
//   buf_addr()  : byte base address of frame buffer idx
package camera_pkg;

  localparam int LANE_W = 16;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    READY,
    HELD
  } buf_state_t;

  typedef enum logic [2:0] {
    WAIT_LOW,
    IDLE,
    CAPTURE,
    DRAIN,
    DROP
  } cap_state_t;

  function automatic logic [31:0] buf_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input int          idx);
    return base + 32'(idx) * stride;
  endfunction

endpackage

// File: rtl/cam_wr_fifo.sv
// Synchronous show-ahead FIFO carrying {address, data} write words.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (pointers only)
//   push        : write push_data when not full (a push while full is ignored)
//   push_data   : entry to store
//   pop         : consume the head entry when not empty
//   head        : current head entry, forced to zero while empty
//   full, empty : occupancy flags
module cam_wr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Storage is not reset, so the head is masked to keep the bus at zero when idle.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/camera_frame_buffer_ctrl.sv
// Captures a sensor pixel stream into one of NUM_BUF frame buffers and hands
// completed frames to the host.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   capture_en                      : capture enable, sampled at frame start
//   pix_frame_valid/line_valid/data : sensor stream; a pixel is taken when both valids are high
//   wr_valid/wr_ready/wr_addr/wr_data : write-master stream. A word transfers on a cycle
//                                     with wr_valid & wr_ready; while wr_valid is high and
//                                     wr_ready low, wr_addr/wr_data hold steady.
//   frame_rdy_irq, current_frame    : a HELD buffer exists / its base address
//   read_done                       : one-cycle pulse, host releases the HELD buffer
//   frames_dropped, frames_bad      : saturating event counters
//   dbg_state                       : capture sequencer state
// line_valid is expected to rise at least one cycle after frame_valid rises;
// pixels presented in the frame_valid rising cycle are not captured.
module camera_frame_buffer_ctrl
  import camera_pkg::*;
#(
  parameter int          PIX_W        = 12,
  parameter int          PIX_PER_WORD = 2,
  parameter int          NUM_BUF      = 3,
  parameter logic [31:0] BUF_BASE     = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE   = 32'h0010_0000,
  parameter int          FRAME_W      = 640,
  parameter int          FRAME_H      = 480,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           capture_en,
  input  logic                           pix_frame_valid,
  input  logic                           pix_line_valid,
  input  logic [PIX_W-1:0]               pix_data,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [31:0]                    wr_addr,
  output logic [LANE_W*PIX_PER_WORD-1:0] wr_data,
  output logic                           frame_rdy_irq,
  output logic [31:0]                    current_frame,
  input  logic                           read_done,
  output logic [15:0]                    frames_dropped,
  output logic [15:0]                    frames_bad,
  output cap_state_t                     dbg_state
);

  localparam int          WORD_W     = LANE_W * PIX_PER_WORD;
  localparam int          IDX_W      = $clog2(NUM_BUF);
  localparam int          LANE_CW    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [31:0] WORD_BYTES = 32'(2 * PIX_PER_WORD);

  cap_state_t         state_q, state_d;
  buf_state_t         buf_q   [NUM_BUF];
  buf_state_t         buf_mid [NUM_BUF];
  buf_state_t         buf_d   [NUM_BUF];
  logic               fv_q, la_q;
  logic               fv_rise, fv_fall, la, line_end;
  logic               pix_take, lane_last, push, bad_set, bad_q;
  logic [LANE_CW-1:0] lane_q;
  logic [15:0]        pix_cnt, line_cnt;
  logic [31:0]        addr_q;
  logic [WORD_W-1:0]  pack_q, push_word;
  logic [LANE_W-1:0]  pix_lane;
  logic [IDX_W-1:0]   fill_idx_q, sel_idx, held_idx, ready_idx;
  logic               held_found, ready_found, sel_found, rd_hit;
  logic               start_cap, drop, publish;
  logic               fifo_full, fifo_empty, irq_d;
  logic [31:0]        cur_d;
  logic [31+WORD_W:0] fifo_head;

  assign fv_rise   = pix_frame_valid & ~fv_q;
  assign fv_fall   = ~pix_frame_valid & fv_q;
  assign la        = pix_frame_valid & pix_line_valid;
  assign line_end  = la_q & ~la;
  assign pix_take  = (state_q == CAPTURE) & la;
  assign lane_last = (lane_q == LANE_CW'(PIX_PER_WORD - 1));
  assign push      = pix_take & lane_last;
  assign start_cap = (state_q == IDLE) & fv_rise & capture_en & sel_found;
  assign drop      = (state_q == IDLE) & fv_rise & ~(capture_en & sel_found);
  assign publish   = (state_q == DRAIN) & fifo_empty;
  assign dbg_state = state_q;

  always_comb begin
    pix_lane = '0;
    pix_lane[PIX_W-1:0] = pix_data;
    push_word = pack_q;
    push_word[(PIX_PER_WORD-1)*LANE_W +: LANE_W] = pix_lane;
  end

  // Capture sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WAIT_LOW;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOW: if (!pix_frame_valid) state_d = IDLE;
      IDLE:     if (fv_rise)          state_d = start_cap ? CAPTURE : DROP;
      CAPTURE:  if (fv_fall)          state_d = DRAIN;
      DRAIN:    if (fifo_empty)       state_d = IDLE;
      DROP:     if (fv_fall)          state_d = IDLE;
      default:                        state_d = WAIT_LOW;
    endcase
  end

  // Frame-size and overflow checks collected into one sticky flag.
  always_comb begin
    bad_set = 1'b0;
    if (state_q == CAPTURE) begin
      if (pix_take && pix_cnt == 16'(FRAME_W))            bad_set = 1'b1;
      if (push && fifo_full)                              bad_set = 1'b1;
      if (line_end && pix_cnt != 16'(FRAME_W))            bad_set = 1'b1;
      if (fv_fall && (line_cnt + 16'(line_end)) != 16'(FRAME_H)) bad_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv_q       <= 1'b0;
      la_q       <= 1'b0;
      lane_q     <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      bad_q      <= 1'b0;
      addr_q     <= '0;
      pack_q     <= '0;
      fill_idx_q <= '0;
    end else begin
      fv_q <= pix_frame_valid;
      la_q <= la;
      if (start_cap) begin
        lane_q     <= '0;
        pix_cnt    <= '0;
        line_cnt   <= '0;
        bad_q      <= 1'b0;
        addr_q     <= buf_addr(BUF_BASE, BUF_STRIDE, int'(sel_idx));
        fill_idx_q <= sel_idx;
      end else begin
        if (bad_set) bad_q <= 1'b1;
        if (pix_take) begin
          pack_q[lane_q*LANE_W +: LANE_W] <= pix_lane;
          if (pix_cnt != 16'(FRAME_W)) pix_cnt <= pix_cnt + 16'd1;
          if (lane_last) begin
            lane_q <= '0;
            addr_q <= addr_q + WORD_BYTES;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        if (line_end && state_q == CAPTURE) begin
          pix_cnt <= '0;
          if (line_cnt != 16'hFFFF) line_cnt <= line_cnt + 16'd1;
        end
      end
    end
  end

  // Buffer rotation. read_done is applied first, then frame start or publish.
  always_comb begin
    held_found  = 1'b0;
    held_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (buf_q[i] == HELD)  begin held_found  = 1'b1; held_idx  = IDX_W'(i); end
      if (buf_q[i] == READY) begin ready_found = 1'b1; ready_idx = IDX_W'(i); end
    end
    rd_hit = read_done & held_found;

    buf_mid = buf_q;
    if (rd_hit) begin
      buf_mid[held_idx] = FREE;
      if (ready_found) buf_mid[ready_idx] = HELD;
    end

    // Lowest FREE buffer wins; otherwise the READY frame is sacrificed.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (buf_mid[i] == FREE) begin sel_found = 1'b1; sel_idx = IDX_W'(i); end
    end
    if (!sel_found) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        if (buf_mid[i] == READY) begin sel_found = 1'b1; sel_idx = IDX_W'(i); end
      end
    end

    buf_d = buf_mid;
    if (start_cap) buf_d[sel_idx] = FILLING;
    if (publish) begin
      if (bad_q) begin
        buf_d[fill_idx_q] = FREE;
      end else if (rd_hit) begin
        // Host just released its frame: the newest frame goes straight to HELD
        // and anything older (including a just-promoted READY) is released.
        for (int i = 0; i < NUM_BUF; i++) begin
          if (buf_d[i] == HELD || buf_d[i] == READY) buf_d[i] = FREE;
        end
        buf_d[fill_idx_q] = HELD;
      end else if (held_found) begin
        for (int i = 0; i < NUM_BUF; i++) begin
          if (buf_d[i] == READY) buf_d[i] = FREE;
        end
        buf_d[fill_idx_q] = READY;
      end else begin
        buf_d[fill_idx_q] = HELD;
      end
    end

    irq_d = 1'b0;
    cur_d = current_frame;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (buf_d[i] == HELD) begin
        irq_d = 1'b1;
        cur_d = buf_addr(BUF_BASE, BUF_STRIDE, i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BUF; i++) buf_q[i] <= FREE;
      frame_rdy_irq  <= 1'b0;
      current_frame  <= BUF_BASE;
      frames_dropped <= '0;
      frames_bad     <= '0;
    end else begin
      buf_q         <= buf_d;
      frame_rdy_irq <= irq_d;
      current_frame <= cur_d;
      if (drop && frames_dropped != 16'hFFFF)               frames_dropped <= frames_dropped + 16'd1;
      if (publish && bad_q && frames_bad != 16'hFFFF)       frames_bad     <= frames_bad + 16'd1;
    end
  end

  cam_wr_fifo #(
    .WIDTH (32 + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({addr_q, push_word}),
    .pop       (wr_valid & wr_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_valid = ~fifo_empty;
  assign wr_addr  = fifo_head[31+WORD_W:WORD_W];
  assign wr_data  = fifo_head[WORD_W-1:0];

endmodule

// File: tb/tb_camera_frame_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_camera_frame_buffer_ctrl;
  import camera_pkg::*;

  localparam int          PIX_W      = 12;
  localparam int          PPW        = 2;
  localparam int          NUM_BUF    = 3;
  localparam int          FRAME_W    = 4;
  localparam int          FRAME_H    = 2;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] BASE       = 32'h1000_0000;
  localparam logic [31:0] STRIDE     = 32'h0010_0000;
  localparam int          WORD_W     = 16 * PPW;
  localparam int          W          = 32 + WORD_W;

  logic              clk;
  logic              reset;
  logic              capture_en;
  logic              fv;
  logic              lv;
  logic [PIX_W-1:0]  pix_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [31:0]       wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              frame_rdy_irq;
  logic [31:0]       current_frame;
  logic              read_done;
  logic [15:0]       frames_dropped;
  logic [15:0]       frames_bad;
  cap_state_t        dbg_state;

  camera_frame_buffer_ctrl #(
    .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .NUM_BUF(NUM_BUF), .BUF_BASE(BASE),
    .BUF_STRIDE(STRIDE), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .pix_frame_valid(fv), .pix_line_valid(lv), .pix_data(pix_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_rdy_irq(frame_rdy_irq), .current_frame(current_frame), .read_done(read_done),
    .frames_dropped(frames_dropped), .frames_bad(frames_bad), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking + reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // Model: which buffer the host holds, which one waits behind it (-1 = none).
  int          m_held;
  int          m_ready;
  logic [31:0] m_cur;
  int          m_dropped;
  int          m_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int idx);
    return BASE + STRIDE * idx;
  endfunction

  task automatic model_reset();
    m_held = -1; m_ready = -1; m_cur = BASE; m_dropped = 0; m_bad = 0;
    exp_q.delete();
  endtask

  // Scoreboard: every accepted write must match the next expected word.
  always @(negedge clk) begin
    if (!reset && wr_valid && wr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL unexpected_write observed addr=0x%0h data=0x%0h expected=none", wr_addr, wr_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[W-1:WORD_W]));
        check("wr_data", 64'(wr_data), 64'(e[WORD_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dbg_state != IDLE && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_reach_idle"}, 64'(dbg_state), 64'(IDLE));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_irq"},     64'(frame_rdy_irq),  64'(m_held >= 0));
    check({tag, "_cur"},     64'(current_frame),  64'(m_cur));
    check({tag, "_dropped"}, 64'(frames_dropped), 64'(m_dropped));
    check({tag, "_bad"},     64'(frames_bad),     64'(m_bad));
  endtask

  task automatic pulse_read_done();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    if (m_held >= 0) begin
      m_held  = m_ready;
      m_ready = -1;
      if (m_held >= 0) m_cur = addr_of(m_held);
    end
  endtask

  // short_line >= 0 shortens that line by one pixel; stall holds wr_ready low
  // for the whole frame.
  task automatic send_frame(input int short_line, input bit stall);
    int           tgt;
    int           nw;
    int           k;
    bit           good;
    logic [15:0]  pix[$];
    logic [WORD_W-1:0] d;
    logic [31:0]  hold_addr;
    logic [WORD_W-1:0] hold_data;

    tgt = -1;
    if (capture_en) begin
      for (int i = 0; i < NUM_BUF; i++)
        if (tgt < 0 && i != m_held && i != m_ready) tgt = i;
      if (tgt < 0 && m_ready >= 0) begin
        tgt = m_ready;
        m_ready = -1;
      end
    end
    if (tgt < 0) m_dropped++;

    for (int l = 0; l < FRAME_H; l++) begin
      int len = (l == short_line) ? FRAME_W - 1 : FRAME_W;
      for (int p = 0; p < len; p++) pix.push_back(16'($urandom_range(0, (1 << PIX_W) - 1)));
    end

    if (tgt >= 0) begin
      nw = pix.size() / PPW;
      if (stall && nw > FIFO_DEPTH) nw = FIFO_DEPTH;
      for (int w = 0; w < nw; w++) begin
        for (int j = 0; j < PPW; j++) d[j*16 +: 16] = pix[w*PPW + j];
        exp_q.push_back({addr_of(tgt) + 32'(w * 2 * PPW), d});
      end
    end

    if (stall) wr_ready = 1'b0;
    fv = 1'b1;
    tick();
    tick();
    k = 0;
    for (int l = 0; l < FRAME_H; l++) begin
      int len = (l == short_line) ? FRAME_W - 1 : FRAME_W;
      for (int p = 0; p < len; p++) begin
        lv = 1'b1;
        pix_data = pix[k][PIX_W-1:0];
        k++;
        tick();
      end
      lv = 1'b0;
      pix_data = '0;
      tick();
      tick();
    end
    fv = 1'b0;

    if (stall) begin
      repeat (3) tick();
      check("stall_valid", 64'(wr_valid), 64'(tgt >= 0));
      hold_addr = wr_addr;
      hold_data = wr_data;
      repeat (4) tick();
      check("stall_addr_stable", 64'(wr_addr), 64'(hold_addr));
      check("stall_data_stable", 64'(wr_data), 64'(hold_data));
      wr_ready = 1'b1;
    end
    wait_idle("frame");

    good = (short_line < 0) && !(stall && (pix.size() / PPW) > FIFO_DEPTH);
    if (tgt >= 0) begin
      if (!good) m_bad++;
      else if (m_held < 0) m_held = tgt;
      else m_ready = tgt;
    end
    if (m_held >= 0) m_cur = addr_of(m_held);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1; capture_en = 1'b1; fv = 1'b0; lv = 1'b0; pix_data = '0;
    wr_ready = 1'b1; read_done = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_wr_valid", 64'(wr_valid), 64'(0));
    check("rst_wr_addr",  64'(wr_addr),  64'(0));
    check("rst_wr_data",  64'(wr_data),  64'(0));
    check("rst_state",    64'(dbg_state), 64'(WAIT_LOW));
    check_outputs("rst");
    reset = 1'b0;
    tick();
    tick();
    check("idle_after_rst", 64'(dbg_state), 64'(IDLE));

    // one good frame into buffer 0
    send_frame(-1, 0);
    check_outputs("t1");

    // two more frames: buffer 1 READY, then buffer 2 READY and buffer 1 freed
    send_frame(-1, 0);
    check_outputs("t2a");
    send_frame(-1, 0);
    check_outputs("t2b");
    pulse_read_done();
    check_outputs("t2_rd");
    pulse_read_done();
    check_outputs("t2_rd_last");
    pulse_read_done();
    check_outputs("t2_rd_ignored");

    // short line: frame rejected, buffer 0 reused by the next frame
    send_frame(0, 0);
    check_outputs("t3_bad");
    send_frame(-1, 0);
    check_outputs("t3_next");

    // write port stalled for a whole frame: FIFO overflows
    send_frame(-1, 1);
    check_outputs("t4_overflow");

    // capture disabled at frame start
    capture_en = 1'b0;
    send_frame(-1, 0);
    capture_en = 1'b1;
    check_outputs("t5_drop");

    // randomized mix of frames, enables, errors and host releases
    for (int r = 0; r < 8; r++) begin
      capture_en = ($urandom_range(0, 3) != 0);
      send_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME_H - 1)) : -1, 0);
      check_outputs("rnd_frame");
      if ($urandom_range(0, 1) == 1) begin
        pulse_read_done();
        check_outputs("rnd_rd");
      end
    end
    capture_en = 1'b1;

    // reset in the middle of a captured frame
    fv = 1'b1;
    tick();
    tick();
    lv = 1'b1;
    pix_data = 12'h5A5;
    tick();
    reset = 1'b1;
    #2;
    model_reset();
    check("midrst_wr_valid", 64'(wr_valid), 64'(0));
    check("midrst_wr_addr",  64'(wr_addr),  64'(0));
    check("midrst_state",    64'(dbg_state), 64'(WAIT_LOW));
    check_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_data = PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
      tick();
    end
    check("midrst_ignore", 64'(dbg_state), 64'(WAIT_LOW));
    lv = 1'b0;
    tick();
    fv = 1'b0;
    tick();
    tick();
    check("midrst_idle", 64'(dbg_state), 64'(IDLE));
    send_frame(-1, 0);
    check_outputs("t6_after_rst");

    repeat (5) tick();
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
